// File: rtl/fft16_pkg.sv
// ----------------------------------------------------------------------------
// fft16_pkg: shared types, sizes and bit-reversal helper for the FFT16 sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fft16_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int TW_W  = 3;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_UNLOAD  = 2'd3
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft16_addr_gen.sv
// ----------------------------------------------------------------------------
// fft16_addr_gen: (stage, butterfly k) -> RAM pair addresses and twiddle index. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fft16_addr_gen
  import fft16_pkg::*;
(
  input  logic [1:0]       stage,
  input  logic [2:0]       k,
  output logic [LOG2N-1:0] addr_m,
  output logic [LOG2N-1:0] addr_n,
  output logic [TW_W-1:0]  tw_index
);

  logic [LOG2N-1:0] kx;
  logic [LOG2N-1:0] h;
  logic [LOG2N-1:0] g;
  logic [LOG2N-1:0] p;

  // h = pair distance, g = group number, p = position within the group
  always_comb begin
    kx       = {1'b0, k};
    h        = 4'd1 << stage;
    g        = kx >> stage;
    p        = kx & (h - 4'd1);
    addr_m   = ((g << stage) << 1) + p;
    addr_n   = addr_m + h;
    tw_index = p[TW_W-1:0] << (2'd3 - stage);
  end

endmodule

`default_nettype wire

// File: rtl/fft16_ctrl.sv
// ----------------------------------------------------------------------------
// fft16_ctrl: 16-point radix-2 DIT FFT sequencer (load / compute / drain / unload). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fft16_ctrl
  import fft16_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_m,
  output logic [LOG2N-1:0] rd_addr_n,
  output logic [TW_W-1:0]  tw_index,
  output logic             wr_en,
  output logic             wr_src,
  output logic [LOG2N-1:0] wr_addr_m,
  output logic [LOG2N-1:0] wr_addr_n,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       cnt;
  logic [1:0]       stage;
  logic [2:0]       drain_cnt;
  logic             drain_last;
  logic             issue;

  logic [LOG2N-1:0] gen_m;
  logic [LOG2N-1:0] gen_n;
  logic [TW_W-1:0]  gen_tw;

  logic [LOG2N-1:0] hold_rd_m;
  logic [LOG2N-1:0] hold_rd_n;
  logic [TW_W-1:0]  hold_tw;
  logic [LOG2N-1:0] hold_wr_m;
  logic [LOG2N-1:0] hold_wr_n;

  logic [PIPE_LAT-1:0] pipe_v;
  logic [LOG2N-1:0]    pipe_m [PIPE_LAT];
  logic [LOG2N-1:0]    pipe_n [PIPE_LAT];

  fft16_addr_gen u_addr_gen (
    .stage    (stage),
    .k        (cnt[2:0]),
    .addr_m   (gen_m),
    .addr_n   (gen_n),
    .tw_index (gen_tw)
  );

  assign drain_last = (drain_cnt == 3'(PIPE_LAT - 1));
  assign issue      = rd_en && (state == ST_COMPUTE);
  assign done       = out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    rd_en     = 1'b0;
    rd_addr_m = hold_rd_m;
    rd_addr_n = hold_rd_n;
    tw_index  = hold_tw;
    wr_en     = 1'b0;
    wr_src    = 1'b0;
    wr_addr_m = hold_wr_m;
    wr_addr_n = hold_wr_n;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en     = 1'b1;
          wr_addr_m = bitrev4(cnt);
          if (cnt == 4'd15) state_nx = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr_m = gen_m;
        rd_addr_n = gen_n;
        tw_index  = gen_tw;
        if (cnt[2:0] == 3'd7) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_nx = (stage == 2'd3) ? ST_UNLOAD : ST_COMPUTE;
      end
      ST_UNLOAD: begin
        busy = 1'b1;
        // out_last marks the trailing cycle where the final sample is presented
        if (out_last) begin
          state_nx = ST_LOAD;
        end else begin
          rd_en     = 1'b1;
          rd_addr_m = cnt;
        end
      end
      default: state_nx = ST_LOAD;
    endcase
    // Write-back port is owned by the delay line; it is empty outside COMPUTE/DRAIN
    if (pipe_v[PIPE_LAT-1]) begin
      wr_en     = 1'b1;
      wr_src    = 1'b1;
      wr_addr_m = pipe_m[PIPE_LAT-1];
      wr_addr_n = pipe_n[PIPE_LAT-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      stage     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) cnt <= cnt + 4'd1;
        end
        ST_COMPUTE: begin
          drain_cnt <= '0;
          cnt       <= (cnt[2:0] == 3'd7) ? 4'd0 : cnt + 4'd1;
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (drain_last) begin
            drain_cnt <= '0;
            cnt       <= '0;
            if (stage != 2'd3) stage <= stage + 2'd1;
          end
        end
        ST_UNLOAD: begin
          if (rd_en) cnt <= cnt + 4'd1;
          if (out_last) stage <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= rd_en && (state == ST_UNLOAD);
      out_last  <= rd_en && (state == ST_UNLOAD) && (cnt == 4'd15);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_rd_m <= '0;
      hold_rd_n <= '0;
      hold_tw   <= '0;
      hold_wr_m <= '0;
      hold_wr_n <= '0;
    end else begin
      if (rd_en) begin
        hold_rd_m <= rd_addr_m;
        hold_rd_n <= rd_addr_n;
        hold_tw   <= tw_index;
      end
      if (wr_en) begin
        hold_wr_m <= wr_addr_m;
        hold_wr_n <= wr_addr_n;
      end
    end
  end

  // Butterfly read-to-write delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_m[i] <= '0;
        pipe_n[i] <= '0;
      end
    end else begin
      pipe_v[0] <= issue;
      pipe_m[0] <= rd_addr_m;
      pipe_n[0] <= rd_addr_n;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_m[i] <= pipe_m[i-1];
        pipe_n[i] <= pipe_n[i-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft16_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft16_ctrl: randomized scoreboard bench for the FFT16 sequencer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fft16_ctrl;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       rd_en;
  logic [3:0] rd_addr_m;
  logic [3:0] rd_addr_n;
  logic [2:0] tw_index;
  logic       wr_en;
  logic       wr_src;
  logic [3:0] wr_addr_m;
  logic [3:0] wr_addr_n;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       done;

  fft16_ctrl #(.PIPE_LAT(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_en     (rd_en),
    .rd_addr_m (rd_addr_m),
    .rd_addr_n (rd_addr_n),
    .tw_index  (tw_index),
    .wr_en     (wr_en),
    .wr_src    (wr_src),
    .wr_addr_m (wr_addr_m),
    .wr_addr_n (wr_addr_n),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       src;
    logic [3:0] m;
    logic [3:0] n;
    logic       last;
  } wr_t;

  typedef struct {
    logic [3:0] m;
    logic [3:0] n;
    logic [2:0] tw;
    logic       unl;
    int         stage;
  } rd_t;

  typedef struct {
    longint cyc;
    int     stage;
  } tm_t;

  wr_t    exp_wr[$];
  rd_t    exp_rd[$];
  logic   exp_out[$];
  tm_t    pend[$];

  int     n_total = 0;
  int     n_pass  = 0;
  int     frames_done = 0;
  bit     mon_en = 1'b0;
  longint cyc = 0;
  longint last_load = 0;
  longint first_unl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [3:0] rev(input int i);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = i[3-b];
    return r;
  endfunction

  // Reference: stage s pairs every index i whose bit s is clear with i+2^s,
  // in ascending order; twiddle exponent is (i mod 2^s) scaled to the 16-point circle.
  function automatic void push_frame_model();
    int h;
    for (int s = 0; s < 4; s++) begin
      h = 1 << s;
      for (int i = 0; i < 16; i++) begin
        if ((i & h) == 0) begin
          exp_rd.push_back('{4'(i), 4'(i + h), 3'((i % h) * (8 / h)), 1'b0, s});
          exp_wr.push_back('{1'b1, 4'(i), 4'(i + h), 1'b0});
        end
      end
    end
    for (int a = 0; a < 16; a++) begin
      exp_rd.push_back('{4'(a), 4'd0, 3'd0, 1'b1, 0});
      exp_out.push_back(a == 15);
    end
  endfunction

  always @(negedge clk) begin : monitor
    rd_t r;
    wr_t w;
    tm_t t;
    logic l;
    if (mon_en) begin
      if (rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          r = exp_rd.pop_front();
          chk("rd_addr_m", 32'(rd_addr_m), 32'(r.m));
          chk("rd_busy", 32'(busy), 32'd1);
          if (!r.unl) begin
            chk("rd_addr_n", 32'(rd_addr_n), 32'(r.n));
            chk("tw_index", 32'(tw_index), 32'(r.tw));
            if (pend.size() > 0) chk("raw_order_stage", 32'(pend[0].stage), 32'(r.stage));
            if (r.stage == 0 && r.m == 4'd0) chk("compute_start", 32'(cyc - last_load), 32'd1);
            pend.push_back('{cyc + P, r.stage});
          end else if (r.m == 4'd0) begin
            first_unl = cyc;
            chk("compute_cycles", 32'(cyc - last_load - 1), 32'(4 * (8 + P)));
          end
        end
      end
      if (wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_src", 32'(wr_src), 32'(w.src));
          chk("wr_addr_m", 32'(wr_addr_m), 32'(w.m));
          if (w.src) begin
            chk("wr_addr_n", 32'(wr_addr_n), 32'(w.n));
            if (pend.size() == 0) chk("wb_without_read", 32'd1, 32'd0);
            else begin
              t = pend.pop_front();
              chk("wb_latency", 32'(cyc), 32'(t.cyc));
            end
          end else if (w.last) begin
            last_load = cyc;
          end
        end
      end
      if (out_valid) begin
        if (exp_out.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
        else begin
          l = exp_out.pop_front();
          chk("out_last", 32'(out_last), 32'(l));
          chk("done", 32'(done), 32'(l));
          if (l) begin
            chk("unload_cycles", 32'(cyc - first_unl), 32'd16);
            frames_done++;
          end
        end
      end else if (done || out_last) begin
        chk("done_without_valid", 32'd1, 32'd0);
      end
      if (busy && in_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
    end
  end

  task automatic run_frame(input bit do_reset);
    int i;
    int fd;
    int w;
    i  = 0;
    fd = frames_done;
    while (i < 16) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        exp_wr.push_back('{1'b0, rev(i), 4'd0, (i == 15)});
        if (i == 15) push_frame_model();
        i++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (do_reset) begin
      repeat (2 * (8 + P) + 4) @(posedge clk);
      #1;
      chk("st2_k4_addr_m", 32'(rd_addr_m), 32'd8);
      chk("st2_k4_addr_n", 32'(rd_addr_n), 32'd12);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_rd_en", 32'(rd_en), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      exp_wr.delete();
      exp_rd.delete();
      exp_out.delete();
      pend.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c <= P; c++) begin
        @(negedge clk);
        chk("midrst_no_wb", 32'(wr_en), 32'd0);
        chk("midrst_load", 32'(in_ready), 32'd1);
      end
      mon_en = 1'b1;
    end else begin
      for (int c = 0; c < 4 * (8 + P) + 10; c++) begin
        in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      w = 0;
      while (frames_done == fd && w < 100) begin
        @(posedge clk);
        w++;
      end
      if (frames_done == fd) chk("frame_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("back_to_load", 32'(in_ready), 32'd1);
      chk("queues_drained", 32'(exp_rd.size() + exp_wr.size() + exp_out.size() + pend.size()), 32'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_quiet", 32'({rd_en, wr_en, wr_src, out_valid, out_last, done, busy}), 32'd0);
    chk("rst_addrs", 32'({rd_addr_m, rd_addr_n, tw_index, wr_addr_m, wr_addr_n}), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    run_frame(1'b0);
    run_frame(1'b0);
    run_frame(1'b1);
    run_frame(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft16_ctrl.md
# fft16_ctrl

Sequencer for the 16-point radix-2 decimation-in-time FFT built around `butterfly_3`. It drives the in-place sample RAM (16 complex words) and the butterfly’s twiddle index through three phases:
- **Load:** 16 input samples are written in bit-reversed order.
- **Compute:** four stages of eight butterflies are issued, one per cycle.
- **Unload:** results are read out in natural order.

The block generates addresses, enables and selects only; sample data never passes through it.

## Interface
Parameters:
- `PIPE_LAT`, default 2: cycles from `rd_en` of a butterfly to valid butterfly outputs (1 RAM read + 1 multiplier register); legal range 1..4.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input sample present on datapath input
- `in_ready`  out  1  controller accepts the input sample this cycle
- `rd_en`  out  1  RAM read strobe, both ports
- `rd_addr_m`  out  4  RAM read address, port m (butterfly upper input / unload address)
- `rd_addr_n`  out  4  RAM read address, port n (butterfly lower input)
- `tw_index`  out  3  twiddle index to `butterfly_3.index`; aligned with `rd_en`
- `wr_en`  out  1  RAM write strobe
- `wr_src`  out  1  0 = input sample on port m, 1 = butterfly results on m and n
- `wr_addr_m`  out  4  RAM write address, port m
- `wr_addr_n`  out  4  RAM write address, port n (ignored when `wr_src`=0)
- `out_valid`  out  1  RAM port-m read data is a valid output sample
- `out_last`  out  1  with `out_valid`, marks sample 15
- `busy`  out  1  high in COMPUTE, DRAIN and UNLOAD
- `done`  out  1  one-cycle pulse after the last output

## Operation
- **States:** LOAD, COMPUTE, DRAIN, UNLOAD.
- **Counters:** `cnt` (4 bits), `stage` (2 bits), `drain_cnt`.
- **LOAD:**
  - `in_ready`=1.
  - On `in_valid`, assert `wr_en`, `wr_src`=0, `wr_addr_m`=bitrev4(`cnt`), then `cnt`++.
  - After accepting sample 15, go to COMPUTE with `stage`=0 and `cnt`=0.
  - Gaps in `in_valid` stall the load without limit.
- **COMPUTE:** issue butterfly k=`cnt[2:0]` each cycle. With s=`stage`, h=1<<s, g=k>>s and p=k&(h-1):
  - `rd_addr_m` = g·2h + p
  - `rd_addr_n` = `rd_addr_m` + h
  - `tw_index` = p<<(3−s)
  - `rd_en`=1
  - After k=7, go to DRAIN.
- **Write-back:** `rd_addr_m`, `rd_addr_n` and the valid bit go through a PIPE_LAT-deep shift register. Its output drives `wr_en`, `wr_addr_m` and `wr_addr_n` with `wr_src`=1. Each write therefore occurs exactly PIPE_LAT cycles after its read.
- **DRAIN:**
  - No issue; stay PIPE_LAT cycles so every write of the stage lands before the next stage reads. This removes the read-after-write hazard.
  - Then, if `stage`<3: `stage`++, `cnt`=0, go to COMPUTE.
  - Otherwise: `cnt`=0, go to UNLOAD.
- **UNLOAD:**
  - `rd_en`=1 with `rd_addr_m`=`cnt`, `cnt`++ each cycle for 16 cycles.
  - `out_valid` is `rd_en` delayed by one cycle; `out_last` accompanies address 15.
  - There is no backpressure.
  - `done` pulses in the cycle `out_last` is high; the next cycle returns to LOAD.
- **Idle-cycle outputs:** `rd_en`, `wr_en`, `out_valid`, `out_last` and `done` are 0 in any cycle not listed above. Addresses hold their last value.
- **Width rules:** address arithmetic is 4-bit unsigned; k≤7 and h≤8 keep every address ≤15, so no wrap-around.

## Timing
- **Reset values:**
  - state=LOAD, all counters 0, shift register cleared.
  - `in_ready`=1 (combinational from state), all other outputs 0.
- **Reset mid-operation:** pending write-backs are discarded, with no `wr_en` after reset. RAM contents are undefined for the next frame until it is reloaded.
- **Latency:**
  - Load: 16 accepted samples.
  - Compute: 4·(8+PIPE_LAT) cycles; 40 at default.
  - Unload: 16 + 1 cycles to the last `out_valid`.
- **Load/write timing:** `in_valid` arriving while not in LOAD is ignored (`in_ready`=0). A load write and a compute write never coincide.
- **Output timing:** all outputs are registered or decoded from registered state, with no input-to-output combinational path except `in_ready`/`wr_en` in LOAD (`wr_en` = `in_valid` & LOAD).

## Structure
- Package `fft16_pkg`:
  - state enum
  - `N`=16, `LOG2N`=4, `TW_W`=3
  - function `bitrev4`
- One sub-module, `fft16_addr_gen`: combinational (`stage`, k) → (`addr_m`, `addr_n`, `tw_index`), which is reusable by the verification model.
- The top contains the FSM, counters and write-back shift register.

## Test plan
- **Load ordering:** 16 back-to-back `in_valid` → `wr_addr_m` sequence begins 0,8,4,12,2,…; sample 3 → address 12, sample 6 → address 6; COMPUTE starts the cycle after sample 15.
- **Address generation:** stage 0 k=7 → m=14, n=15, tw=0; stage 1 k=5 → m=9, n=11, tw=4; stage 3 k=3 → m=3, n=11, tw=3.
- **Write-back alignment (PIPE_LAT=2):** every `wr_en` occurs 2 cycles after its `rd_en` with identical addresses; no stage-(s+1) read precedes the last stage-s write; compute occupies exactly 40 cycles.
- **End-to-end:** impulse at sample 0 through `butterfly_3` + RAM model → all 16 outputs equal the input real value with imaginary 0; `out_last` and `done` are coincident on the 16th `out_valid`.
- **Stalled load:** `in_valid` toggled 1-0-1 → only accepted samples advance `cnt`; `in_valid` during COMPUTE/UNLOAD is ignored.
- **Reset mid-operation:** `rst` asserted at stage 2 k=4 → next cycle state=LOAD, `in_ready`=1, `wr_en`=0 for the following PIPE_LAT cycles.
